truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Exhaustive characteriser for generated minimized-logic modules: drives every input combination
//  into the combinational SOP block under test, samples its output F, and rebuilds the truth table.
//  Compares the captured table against the expected minterm mask and reports pass/fail.
//  Sits beside the generated logic on-chip or in the bench as its self-check harness.
// PARAMETERS
//  N_IN   4  number of logic inputs swept (drv[N_IN-1] = A, drv[0] = last variable)
//  SETTLE 1  extra cycles each vector is held before F is sampled (0 allowed)
// PORTS
//  clk           in   1          single clock, all state on rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  start         in   1          begin sweep; honoured only in IDLE
//  abort         in   1          cancel sweep; return to IDLE without done
//  expected_mask in   2**N_IN    bit k = expected F for input value k; latched on accepted start
//  drv           out  N_IN       input vector to block under test
//  f_in          in   1          F returned by block under test
//  busy          out  1          high while sweeping
//  done          out  1          one-cycle pulse when sweep completes
//  pass          out  1          captured == latched mask; valid from done until next start
//  captured      out  2**N_IN    bit k = sampled F for vector k
//  fail_count    out  N_IN+1     number of mismatching vectors
//  first_fail    out  N_IN       lowest mismatching vector index; 0 if none
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; drv, captured, fail_count, first_fail = 0; busy, done, pass = 0.
//  FSM: IDLE -> HOLD on start; HOLD -> SAMPLE after SETTLE cycles (immediately if SETTLE=0);
//   SAMPLE -> HOLD (next vector) or DONE (last vector); DONE -> IDLE after one cycle.
//  Accepted start (edge E): latch mask; clear captured, fail_count, first_fail, pass; drv=0; busy=1.
//  Each vector occupies exactly SETTLE+1 cycles; f_in sampled on that window's final edge.
//  On sample of vector k: captured[k]=f_in; on mismatch fail_count++ and, if first, first_fail=k.
//  drv increments on the sample edge; never wraps past 2**N_IN-1 (held at max into DONE).
//  Busy for exactly 2**N_IN*(SETTLE+1) cycles; done=1 and busy=0 in the following cycle only.
//  pass set with done iff fail_count==0; held until next accepted start or reset.
//  start while busy/DONE: ignored, no effect. start and abort together in IDLE: abort wins.
//  abort while busy: next edge -> IDLE, busy=0, drv=0, done not pulsed, pass=0; captured,
//   fail_count, first_fail keep partial values.
//  expected_mask changes during sweep: ignored (latched copy used).
//  fail_count range 0..2**N_IN; width N_IN+1 prevents overflow.
// TESTING (N_IN=4; block under test F = A'BD + BCD' + ACD + AB'C'D', minterms 5,6,7,8,11,14,15)
//  1. SETTLE=1, mask=0xC9E0, start -> busy 32 cycles, done pulse, pass=1, captured=0xC9E0, fail_count=0.
//  2. mask=0xC8E0 (bit 8 cleared) -> pass=0, fail_count=1, first_fail=8, captured=0xC9E0.
//  3. mask=0x361F (inverted) -> pass=0, fail_count=16, first_fail=0.
//  4. SETTLE=0, mask=0xC9E0 -> busy exactly 16 cycles, drv steps 0..15 one per cycle, pass=1.
//  5. abort 10 cycles after start -> busy=0 next cycle, no done, drv=0; restart completes with pass=1.
//  6. start pulsed mid-sweep -> ignored, sweep length unchanged; rst_n low mid-sweep -> all outputs 0 at once.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Bundle of signals between the truth-table sweeper and whoever controls it.
// The block under test is driven through drv and answers on f_in.
//   master : controller side, drives start/abort/expected_mask and returns f_in
//   slave  : sweeper side, drives drv and all result/status signals
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   expected_mask;
  logic [N_IN-1:0]      drv;
  logic                 f_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   captured;
  logic [N_IN:0]        fail_count;
  logic [N_IN-1:0]      first_fail;

  modport master (
    output start, abort, expected_mask, f_in,
    input  drv, busy, done, pass, captured, fail_count, first_fail
  );

  modport slave (
    input  start, abort, expected_mask, f_in,
    output drv, busy, done, pass, captured, fail_count, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for a combinational block under test.
// Walks drv through every input value, holds each for SETTLE+1 cycles, samples
// f_in on the last edge of that window, rebuilds the truth table in captured and
// compares it with the expected minterm mask latched at start.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of truth_table_sweeper_if (start/abort/expected_mask/f_in
//           in; drv/busy/done/pass/captured/fail_count/first_fail out)
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int SL = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SL);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // With no settle time a vector goes straight to its sampling cycle.
  localparam logic [1:0] VEC_ENTRY = (SETTLE == 0) ? SAMPLE : HOLD;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] drv_q, drv_d;
  logic [NV-1:0]   mask_q, mask_d;
  logic [NV-1:0]   captured_q, captured_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;

  logic            mismatch;
  logic [N_IN:0]   fail_inc;
  logic            last_vec;

  assign mismatch = bus.f_in != mask_q[drv_q];
  assign fail_inc = fail_q + {{N_IN{1'b0}}, mismatch};
  assign last_vec = &drv_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drv_d      = drv_q;
    mask_d     = mask_q;
    captured_d = captured_q;
    fail_d     = fail_q;
    first_d    = first_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        // abort suppresses a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d    = VEC_ENTRY;
          cnt_d      = '0;
          drv_d      = '0;
          mask_d     = bus.expected_mask;
          captured_d = '0;
          fail_d     = '0;
          first_d    = '0;
          pass_d     = 1'b0;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
          drv_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        // abort on the sampling edge discards that vector's sample
        if (bus.abort) begin
          state_d = IDLE;
          drv_d   = '0;
          pass_d  = 1'b0;
        end else begin
          captured_d[drv_q] = bus.f_in;
          fail_d            = fail_inc;
          if (mismatch && (fail_q == '0)) begin
            first_d = drv_q;
          end
          if (last_vec) begin
            // drv stays at the top value rather than wrapping
            state_d = DONE;
            pass_d  = (fail_inc == '0);
          end else begin
            state_d = VEC_ENTRY;
            drv_d   = drv_q + {{(N_IN-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drv_q      <= '0;
      mask_q     <= '0;
      captured_q <= '0;
      fail_q     <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drv_q      <= drv_d;
      mask_q     <= mask_d;
      captured_q <= captured_d;
      fail_q     <= fail_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.drv        = drv_q;
  assign bus.busy       = (state_q == HOLD) || (state_q == SAMPLE);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.captured   = captured_q;
  assign bus.fail_count = fail_q;
  assign bus.first_fail = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// Two sweepers (SETTLE=1 and SETTLE=0) each drive their own copy of the
// block under test F = A'BD + BCD' + ACD + AB'C'D' (minterms 5,6,7,8,11,14,15).
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  truth_table_sweeper_if #(.N_IN(4)) ifSlow ();
  truth_table_sweeper_if #(.N_IN(4)) ifFast ();

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dutSlow (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifSlow.slave)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) dutFast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifFast.slave)
  );

  function automatic logic fGate(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3];
    b = v[2];
    c = v[1];
    d = v[0];
    return (~a & b & d) | (b & c & ~d) | (a & c & d) | (a & ~b & ~c & ~d);
  endfunction

  assign ifSlow.f_in = fGate(ifSlow.drv);
  assign ifFast.f_in = fGate(ifFast.drv);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          useFast;
  logic        selBusy, selDone, selPass;
  logic [15:0] selCaptured;
  logic [4:0]  selFail;
  logic [3:0]  selFirst, selDrv;

  assign selBusy     = useFast ? ifFast.busy       : ifSlow.busy;
  assign selDone     = useFast ? ifFast.done       : ifSlow.done;
  assign selPass     = useFast ? ifFast.pass       : ifSlow.pass;
  assign selCaptured = useFast ? ifFast.captured   : ifSlow.captured;
  assign selFail     = useFast ? ifFast.fail_count : ifSlow.fail_count;
  assign selFirst    = useFast ? ifFast.first_fail : ifSlow.first_fail;
  assign selDrv      = useFast ? ifFast.drv        : ifSlow.drv;

  typedef struct {
    bit          fast;
    logic [15:0] mask;
    bit          midStart;
    int          expBusy;
    bit          expPass;
    int          expFail;
    int          expFirst;
    logic [15:0] expCap;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setStart(input bit v);
    if (useFast) ifFast.start = v;
    else         ifSlow.start = v;
  endtask

  task automatic setAbort(input bit v);
    if (useFast) ifFast.abort = v;
    else         ifSlow.abort = v;
  endtask

  task automatic setMask(input logic [15:0] m);
    if (useFast) ifFast.expected_mask = m;
    else         ifSlow.expected_mask = m;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_drv"},      selDrv,      0);
    checkOutput({tag, "_busy"},     selBusy,     0);
    checkOutput({tag, "_done"},     selDone,     0);
    checkOutput({tag, "_pass"},     selPass,     0);
    checkOutput({tag, "_captured"}, selCaptured, 0);
    checkOutput({tag, "_failcnt"},  selFail,     0);
    checkOutput({tag, "_first"},    selFirst,    0);
  endtask

  // Runs one full sweep from a start pulse to the done pulse and checks results.
  task automatic applyStimulus(input vec_t v, input int idx);
    int  busyCycles;
    int  drvErr;
    int  settle;
    bit  sawDone;
    string tag;
    tag = $sformatf("vec%0d", idx);
    useFast = v.fast;
    settle  = v.fast ? 0 : 1;
    @(negedge clk);
    setMask(v.mask);
    setStart(1'b1);
    @(negedge clk);
    setStart(1'b0);
    busyCycles = 0;
    drvErr     = 0;
    sawDone    = 0;
    for (int c = 0; c < 200 && !sawDone; c++) begin
      if (selDone) begin
        sawDone = 1;
      end else begin
        if (selBusy) begin
          if (selDrv !== 4'(busyCycles / (settle + 1))) drvErr++;
          busyCycles++;
        end
        if (v.midStart && c == 8) begin
          setStart(1'b1);
          setMask(16'h0000);
        end else begin
          setStart(1'b0);
        end
        @(negedge clk);
      end
    end
    setStart(1'b0);
    checkOutput({tag, "_done_seen"},  sawDone,     1);
    checkOutput({tag, "_busy_cyc"},   busyCycles,  v.expBusy);
    checkOutput({tag, "_drv_steps"},  drvErr,      0);
    checkOutput({tag, "_busy_at_done"}, selBusy,   0);
    checkOutput({tag, "_drv_held"},   selDrv,      4'hF);
    checkOutput({tag, "_pass"},       selPass,     v.expPass);
    checkOutput({tag, "_captured"},   selCaptured, v.expCap);
    checkOutput({tag, "_failcnt"},    selFail,     v.expFail);
    checkOutput({tag, "_first"},      selFirst,    v.expFirst);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, selDone,     0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_pass_held"},  selPass,     v.expPass);
  endtask

  int doneCount;

  initial begin
    vecs[0] = '{fast:0, mask:16'hC9E0, midStart:0, expBusy:32, expPass:1, expFail:0,  expFirst:0,  expCap:16'hC9E0};
    vecs[1] = '{fast:0, mask:16'hC8E0, midStart:0, expBusy:32, expPass:0, expFail:1,  expFirst:8,  expCap:16'hC9E0};
    vecs[2] = '{fast:0, mask:16'h361F, midStart:0, expBusy:32, expPass:0, expFail:16, expFirst:0,  expCap:16'hC9E0};
    vecs[3] = '{fast:1, mask:16'hC9E0, midStart:0, expBusy:16, expPass:1, expFail:0,  expFirst:0,  expCap:16'hC9E0};
    vecs[4] = '{fast:0, mask:16'hC9E0, midStart:1, expBusy:32, expPass:1, expFail:0,  expFirst:0,  expCap:16'hC9E0};
    vecs[5] = '{fast:1, mask:16'h361F, midStart:0, expBusy:16, expPass:0, expFail:16, expFirst:0,  expCap:16'hC9E0};
    vecs[6] = '{fast:1, mask:16'h49E0, midStart:0, expBusy:16, expPass:0, expFail:1,  expFirst:15, expCap:16'hC9E0};

    rst_n = 1'b0;
    ifSlow.start = 0; ifSlow.abort = 0; ifSlow.expected_mask = '0;
    ifFast.start = 0; ifFast.abort = 0; ifFast.expected_mask = '0;
    useFast = 0;
    #3;
    checkAllZero("reset_slow");
    useFast = 1;
    #1;
    checkAllZero("reset_fast");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // start and abort together in IDLE: abort wins
    useFast = 0;
    @(negedge clk);
    setMask(16'hC9E0);
    setStart(1'b1);
    setAbort(1'b1);
    @(negedge clk);
    setStart(1'b0);
    setAbort(1'b0);
    checkOutput("start_abort_idle_busy", selBusy, 0);
    @(negedge clk);
    checkOutput("start_abort_idle_busy2", selBusy, 0);

    // abort ten cycles into a sweep with an all-mismatch mask
    setMask(16'h361F);
    setStart(1'b1);
    @(negedge clk);
    setStart(1'b0);
    repeat (9) @(negedge clk);
    checkOutput("abort_busy_before", selBusy, 1);
    setAbort(1'b1);
    @(negedge clk);
    setAbort(1'b0);
    checkOutput("abort_busy",     selBusy,     0);
    checkOutput("abort_done",     selDone,     0);
    checkOutput("abort_drv",      selDrv,      0);
    checkOutput("abort_pass",     selPass,     0);
    checkOutput("abort_failcnt",  selFail,     4);
    checkOutput("abort_first",    selFirst,    0);
    checkOutput("abort_captured", selCaptured, 0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (selDone) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(vecs[0], 7);

    // asynchronous reset in the middle of a sweep
    useFast = 0;
    @(negedge clk);
    setMask(16'h361F);
    setStart(1'b1);
    @(negedge clk);
    setStart(1'b0);
    repeat (5) @(negedge clk);
    checkOutput("midrst_failcnt_before", selFail, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle_busy", selBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
